mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit (MULTU, MULT, DIVU, DIV) working on operand magnitudes.
// Latency: result and done pulse 32 edges after the accepting edge (1 edge for divide-by-zero).
// Backpressure: no queueing; start is sampled only in IDLE and ignored while busy is high.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operandA,
  input  logic [DATA_W-1:0] operandB,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero
);

  localparam int               CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Control strobes from the FSM
  logic accept;       // IDLE edge that latches a new operation
  logic load_result;  // RUN -> DONE edge that writes hi/lo

  // Latched operation context
  logic              div_q,     div_d;      // 1: divide, 0: multiply
  logic              dz_q,      dz_d;       // divide with zero divisor pending
  logic              neg_res_q, neg_res_d;  // negate product / quotient at the end
  logic              neg_rem_q, neg_rem_d;  // negate remainder at the end
  logic [DATA_W-1:0] a_q,       a_d;        // raw dividend, returned as hi on divide-by-zero
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  // Multiply datapath: 64-bit accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [2*DATA_W-1:0] acc_q,    acc_d;
  logic [2*DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;

  // Divide datapath: 33-bit partial remainder, dividend/quotient shift register, divisor
  logic [DATA_W:0]     rem_q,  rem_d;
  logic [DATA_W-1:0]   quo_q,  quo_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;

  // Result registers
  logic [DATA_W-1:0] hi_q,  hi_d;
  logic [DATA_W-1:0] lo_q,  lo_d;
  logic              dbz_q, dbz_d;

  // Operand magnitudes for the signed ops (op[0] = signed)
  logic              a_neg_in, b_neg_in;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign a_neg_in = op[0] & operandA[DATA_W-1];
  assign b_neg_in = op[0] & operandB[DATA_W-1];
  assign a_mag    = a_neg_in ? -operandA : operandA;
  assign b_mag    = b_neg_in ? -operandB : operandB;

  // One iteration of each datapath, also used directly for the final result load
  logic [2*DATA_W-1:0] acc_step;
  logic [DATA_W+1:0]   div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [DATA_W:0]     rem_step;
  logic [DATA_W-1:0]   quo_step;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign div_shift = {rem_q, quo_q[DATA_W-1]};
  assign div_ge    = (div_shift >= {2'b00, dvsr_q});
  assign div_diff  = div_shift[DATA_W:0] - {1'b0, dvsr_q};
  assign rem_step  = div_ge ? div_diff : div_shift[DATA_W:0];
  assign quo_step  = {quo_q[DATA_W-2:0], div_ge};

  // FSM next state and control outputs
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    load_result = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // A zero divisor skips the iteration loop entirely
        if (dz_q || (cnt_q == LAST_STEP)) begin
          load_result = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: latch on accept, iterate in RUN, fix signs on the final load
  always_comb begin
    div_d     = div_q;
    dz_d      = dz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    if (accept) begin
      div_d     = op[1];
      dz_d      = op[1] & (operandB == '0);
      neg_res_d = a_neg_in ^ b_neg_in;
      neg_rem_d = a_neg_in;
      a_d       = operandA;
      cnt_d     = '0;
      acc_d     = '0;
      mcand_d   = {{DATA_W{1'b0}}, a_mag};
      mplier_d  = b_mag;
      rem_d     = '0;
      quo_d     = a_mag;
      dvsr_d    = b_mag;
    end else if ((state_q == S_RUN) && !dz_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        rem_d = rem_step;
        quo_d = quo_step;
      end else begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end

    if (load_result) begin
      dbz_d = dz_q;
      if (dz_q) begin
        hi_d = a_q;
        lo_d = '1;
      end else if (div_q) begin
        hi_d = neg_rem_q ? -rem_step[DATA_W-1:0] : rem_step[DATA_W-1:0];
        lo_d = neg_res_q ? -quo_step : quo_step;
      end else begin
        {hi_d, lo_d} = neg_res_q ? -acc_step : acc_step;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      dz_q      <= dz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  // The flag register holds its value; it is only presented during the DONE cycle
  assign div_by_zero = dbz_q & (state_q == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
`timescale 1ns/1ps
// Bench for mult_div_unit: directed corner cases plus randomised back-to-back operations.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operandA    (operandA),
    .operandB    (operandB),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} straight from the arithmetic definition of each op
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0:    r = {32'd0, a} * {32'd0, b};
      2'd1:    r = 64'(sa * sb);
      2'd2:    r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
    endcase
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    op       = 2'($urandom_range(0, 3));
    operandA = $urandom;
    operandB = $urandom;
  endtask

  // Present an operation for one edge (E0), then scramble the inputs
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op       = o;
    operandA = a;
    operandB = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    scramble();
  endtask

  // Count edges after E0 until done; random start pulses while busy must be ignored
  task automatic wait_done(output int lat, output logic [31:0] h, output logic [31:0] l, output logic dz);
    lat = -1;
    h   = '0;
    l   = '0;
    dz  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (lat < 0) begin
        tick();
        if (done === 1'b1) begin
          lat   = c;
          h     = hi;
          l     = lo;
          dz    = div_by_zero;
          start = 1'b0;
        end else begin
          start = 1'($urandom_range(0, 1));
          scramble();
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/dbz=%b required 000", {busy, done, div_by_zero});
    end
    checks++;
    if ({hi, lo} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo: got %h required 0", {hi, lo});
    end
    tick();
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_held: busy/done=%b required 00", {busy, done});
    end
    rst = 1'b0;
  endtask

  task automatic test_multu_max;
    int lat; logic [31:0] h, l; logic dz;
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL multu_busy: got %b required 1", busy);
    end
    wait_done(lat, h, l, dz);
    checks++;
    if (lat !== 32) begin
      failures++;
      $display("FAIL multu_latency: got %0d required 32", lat);
    end
    checks++;
    if ({h, l, dz} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
      failures++;
      $display("FAIL multu_result: hi=%h lo=%h dbz=%b required fffffffe 00000001 0", h, l, dz);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin
      failures++;
      $display("FAIL multu_after: busy/done=%b hi=%h lo=%h required 00 fffffffe 00000001", {busy, done}, hi, lo);
    end
  endtask

  // Signed multiply and divide corner cases with fixed expected values
  task automatic test_signed_table;
    logic [1:0]  t_op [5];
    logic [31:0] t_a  [5];
    logic [31:0] t_b  [5];
    logic [63:0] t_r  [5];
    int lat; logic [31:0] h, l; logic dz;
    t_op[0] = 2'd1; t_a[0] = 32'hFFFF_FFFD; t_b[0] = 32'd5;         t_r[0] = {32'hFFFF_FFFF, 32'hFFFF_FFF1};
    t_op[1] = 2'd1; t_a[1] = 32'h8000_0000; t_b[1] = 32'h8000_0000; t_r[1] = {32'h4000_0000, 32'h0};
    t_op[2] = 2'd3; t_a[2] = 32'hFFFF_FFF9; t_b[2] = 32'd2;         t_r[2] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    t_op[3] = 2'd2; t_a[3] = 32'd100;       t_b[3] = 32'd7;         t_r[3] = {32'd2, 32'd14};
    t_op[4] = 2'd3; t_a[4] = 32'h8000_0000; t_b[4] = 32'hFFFF_FFFF; t_r[4] = {32'h0, 32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(lat, h, l, dz);
      checks++;
      if (lat !== 32 || dz !== 1'b0) begin
        failures++;
        $display("FAIL table%0d_timing: latency=%0d dbz=%b required 32 0", i, lat, dz);
      end
      checks++;
      if ({h, l} !== t_r[i]) begin
        failures++;
        $display("FAIL table%0d_result: got %h required %h", i, {h, l}, t_r[i]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [31:0] h, l; logic dz;
    issue(2'd2, 32'h0000_1234, 32'd0);
    wait_done(lat, h, l, dz);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL dz_latency: got %0d required 1", lat);
    end
    checks++;
    if ({dz, h, l} !== {1'b1, 32'h0000_1234, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL dz_result: dbz=%b hi=%h lo=%h required 1 00001234 ffffffff", dz, h, l);
    end
    tick();
    checks++;
    if ({div_by_zero, done, busy} !== 3'b000) begin
      failures++;
      $display("FAIL dz_after: dbz/done/busy=%b required 000", {div_by_zero, done, busy});
    end
    // Idle with start low: outputs must hold whatever the inputs do
    for (int i = 0; i < 5; i++) begin
      scramble();
      tick();
      checks++;
      if ({busy, done, hi, lo} !== {2'b00, 32'h0000_1234, 32'hFFFF_FFFF}) begin
        failures++;
        $display("FAIL idle_hold%0d: busy/done=%b hi=%h lo=%h", i, {busy, done}, hi, lo);
      end
    end
    issue(2'd3, 32'h8765_4321, 32'd0);
    wait_done(lat, h, l, dz);
    checks++;
    if ({lat == 1, dz, h, l} !== {1'b1, 1'b1, 32'h8765_4321, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL dz_signed: latency=%0d dbz=%b hi=%h lo=%h required 1 1 87654321 ffffffff", lat, dz, h, l);
    end
    tick();
  endtask

  task automatic test_abort;
    int lat; logic [31:0] h, l; logic dz;
    logic seen;
    seen = 1'b0;
    issue(2'd0, 32'd6, 32'd7);
    for (int e = 1; e <= 19; e++) begin
      if (e == 10) begin
        start = 1'b1; op = 2'd0; operandA = 32'd9; operandB = 32'd11;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    rst   = 1'b1;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL abort_clear: busy/done=%b hi=%h lo=%h required all zero", {busy, done}, hi, lo);
    end
    tick();
    if (done === 1'b1) seen = 1'b1;
    rst = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: a done/busy appeared after the abort, got %b required 0", seen);
    end
    issue(2'd0, 32'd6, 32'd7);
    wait_done(lat, h, l, dz);
    checks++;
    if (lat !== 32 || {h, l} !== 64'd42) begin
      failures++;
      $display("FAIL abort_rerun: latency=%0d result=%h required 32 42", lat, {h, l});
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat, exp_lat; logic [31:0] h, l; logic dz;
    logic [1:0] o; logic [31:0] a, b; logic [63:0] exp_r;
    for (int n = 0; n < 60; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        3: b = {16'hFFFF, b[15:0]};
        default: ;
      endcase
      exp_r   = ref_result(o, a, b);
      exp_lat = (o[1] && b == 32'd0) ? 1 : 32;
      issue(o, a, b);
      wait_done(lat, h, l, dz);
      checks++;
      if (lat !== exp_lat || dz !== (o[1] && b == 32'd0)) begin
        failures++;
        $display("FAIL b2b%0d_timing: op=%0d latency=%0d dbz=%b required %0d", n, o, lat, dz, exp_lat);
      end
      checks++;
      if ({h, l} !== exp_r) begin
        failures++;
        $display("FAIL b2b%0d_result: op=%0d a=%h b=%h got %h required %h", n, o, a, b, {h, l}, exp_r);
      end
      tick();
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
        failures++;
        $display("FAIL b2b%0d_idle: busy/done/dbz=%b required 000", n, {busy, done, div_by_zero});
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    op       = 2'd0;
    operandA = 32'd0;
    operandB = 32'd0;
    #1;
    test_reset();
    test_multu_max();
    test_signed_table();
    test_div_zero();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
